// File: rtl/com_fifo_pkg.sv
// com_fifo_pkg: shared read-mode constants, occupancy width and threshold legality helpers
package com_fifo_pkg;
  localparam int C_FIFO_STD  = 0;
  localparam int C_FIFO_FWFT = 1;
  function automatic int occ_w(input int addr_w);
    return addr_w + 1;
  endfunction
  function automatic bit th_legal(input int addr_w, input int afull_th, input int aempty_th);
    return addr_w >= 2 && aempty_th >= 0 && aempty_th < afull_th && afull_th >= 1 && afull_th <= 2 ** addr_w;
  endfunction
endpackage

// File: rtl/com_dpram_dist.sv
// com_dpram_dist: simple dual-port distributed RAM, one sync write port, async read
module com_dpram_dist #(
  parameter int DATA_W = 28,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= din;
  assign dout = mem[raddr];
endmodule

// File: rtl/com_sync_fifo_param.sv
// com_sync_fifo_param: single-clock FIFO with standard/FWFT read, programmable thresholds, sticky errors
module com_sync_fifo_param
  import com_fifo_pkg::*;
#(
  parameter int DATA_W    = 28,
  parameter int ADDR_W    = 5,
  parameter int FWFT      = C_FIFO_STD,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 2
) (
  input  logic              I_fifo_clk,
  input  logic              I_fifo_rst,
  input  logic [DATA_W-1:0] I_fifo_din,
  input  logic              I_fifo_wr,
  input  logic              I_fifo_rd,
  input  logic              I_fifo_err_clr,
  output logic [DATA_W-1:0] O_fifo_dout,
  output logic              O_fifo_empty,
  output logic              O_fifo_full,
  output logic              O_fifo_afull,
  output logic              O_fifo_aempty,
  output logic [ADDR_W:0]   O_fifo_usedw,
  output logic              O_fifo_ovf,
  output logic              O_fifo_udf
);
  localparam int OW = occ_w(ADDR_W);
  localparam logic [OW-1:0] AF   = OW'(AFULL_TH);
  localparam logic [OW-1:0] AE   = OW'(AEMPTY_TH);
  localparam logic [OW-1:0] FULL = OW'(2 ** ADDR_W);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] usedw, occ_n;
  logic empty, full, afull, aempty, ovf, udf, wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_q;
  if (!th_legal(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("com_sync_fifo_param: illegal ADDR_W/AFULL_TH/AEMPTY_TH combination");
  end
  always_comb begin
    wr_acc = I_fifo_wr & ~full;
    rd_acc = I_fifo_rd & ~empty;
    occ_n  = I_fifo_rst ? '0 : usedw + OW'(wr_acc) - OW'(rd_acc);
  end
  // every flag is derived from the next count so it lands together with usedw
  always_ff @(posedge I_fifo_clk) begin
    usedw  <= occ_n;
    empty  <= occ_n == '0;
    full   <= occ_n == FULL;
    afull  <= occ_n >= AF;
    aempty <= occ_n <= AE;
    wr_ptr <= I_fifo_rst ? '0 : wr_ptr + ADDR_W'(wr_acc);
    rd_ptr <= I_fifo_rst ? '0 : rd_ptr + ADDR_W'(rd_acc);
    ovf    <= ~I_fifo_rst & ((I_fifo_wr & full) | (ovf & ~I_fifo_err_clr));
    udf    <= ~I_fifo_rst & ((I_fifo_rd & empty) | (udf & ~I_fifo_err_clr));
  end
  com_dpram_dist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk  (I_fifo_clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .din  (I_fifo_din),
    .raddr(rd_ptr),
    .dout (ram_q)
  );
  if (FWFT == C_FIFO_FWFT) begin : g_fwft
    // masked while empty so the output is deterministic when nothing is stored
    assign O_fifo_dout = empty ? '0 : ram_q;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge I_fifo_clk)
      if (I_fifo_rst) dout_q <= '0;
      else if (rd_acc) dout_q <= ram_q;
    assign O_fifo_dout = dout_q;
  end
  assign O_fifo_usedw  = usedw;
  assign O_fifo_empty  = empty;
  assign O_fifo_full   = full;
  assign O_fifo_afull  = afull;
  assign O_fifo_aempty = aempty;
  assign O_fifo_ovf    = ovf;
  assign O_fifo_udf    = udf;
endmodule

// File: tb/tb_com_sync_fifo_param.sv
// tb_com_sync_fifo_param: vector table plus directed and randomized checks for com_sync_fifo_param
module tb_com_sync_fifo_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, wr0, rd0, clr0, empty0, full0, afull0, aempty0, ovf0, udf0;
  logic [27:0] din0, dout0;
  logic [5:0] usedw0;
  logic rst1, wr1, rd1, clr1, empty1, full1, afull1, aempty1, ovf1, udf1;
  logic [27:0] din1, dout1;
  logic [5:0] usedw1;
  logic rst2, wr2, rd2, clr2;
  logic [7:0] din2, dout2, dout3;
  logic empty2, full2, afull2, aempty2, ovf2, udf2;
  logic empty3, full3, afull3, aempty3, ovf3, udf3;
  logic [3:0] usedw2, usedw3;

  com_sync_fifo_param u_d0 (
    .I_fifo_clk(clk), .I_fifo_rst(rst0), .I_fifo_din(din0), .I_fifo_wr(wr0), .I_fifo_rd(rd0),
    .I_fifo_err_clr(clr0), .O_fifo_dout(dout0), .O_fifo_empty(empty0), .O_fifo_full(full0),
    .O_fifo_afull(afull0), .O_fifo_aempty(aempty0), .O_fifo_usedw(usedw0), .O_fifo_ovf(ovf0), .O_fifo_udf(udf0));
  com_sync_fifo_param #(.FWFT(1)) u_d1 (
    .I_fifo_clk(clk), .I_fifo_rst(rst1), .I_fifo_din(din1), .I_fifo_wr(wr1), .I_fifo_rd(rd1),
    .I_fifo_err_clr(clr1), .O_fifo_dout(dout1), .O_fifo_empty(empty1), .O_fifo_full(full1),
    .O_fifo_afull(afull1), .O_fifo_aempty(aempty1), .O_fifo_usedw(usedw1), .O_fifo_ovf(ovf1), .O_fifo_udf(udf1));
  com_sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_d2 (
    .I_fifo_clk(clk), .I_fifo_rst(rst2), .I_fifo_din(din2), .I_fifo_wr(wr2), .I_fifo_rd(rd2),
    .I_fifo_err_clr(clr2), .O_fifo_dout(dout2), .O_fifo_empty(empty2), .O_fifo_full(full2),
    .O_fifo_afull(afull2), .O_fifo_aempty(aempty2), .O_fifo_usedw(usedw2), .O_fifo_ovf(ovf2), .O_fifo_udf(udf2));
  com_sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) u_d3 (
    .I_fifo_clk(clk), .I_fifo_rst(rst2), .I_fifo_din(din2), .I_fifo_wr(wr2), .I_fifo_rd(rd2),
    .I_fifo_err_clr(clr2), .O_fifo_dout(dout3), .O_fifo_empty(empty3), .O_fifo_full(full3),
    .O_fifo_afull(afull3), .O_fifo_aempty(aempty3), .O_fifo_usedw(usedw3), .O_fifo_ovf(ovf3), .O_fifo_udf(udf3));

  typedef struct {
    logic wr, rd, clr;
    logic [27:0] din;
    logic [5:0] usedw;
    logic empty, full, afull, aempty, ovf, udf;
    logic [27:0] dout;
  } vec_t;

  vec_t tbl[$];
  logic [27:0] q0[$];
  logic [7:0] q2[$];
  logic [27:0] dv, ev;
  logic [7:0] m_dout;
  logic m_ovf, m_udf, s_ovf, s_udf;
  int checks = 0, errors = 0, n, w_pct;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, rd, clr, input logic [27:0] din, input logic [5:0] u,
                              input logic ovf, udf, input logic [27:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.usedw = u;
    v.empty = u == 6'd0; v.full = u == 6'd32; v.afull = u >= 6'd28; v.aempty = u <= 6'd2;
    v.ovf = ovf; v.udf = udf; v.dout = dout;
    return v;
  endfunction

  task automatic cyc0(input logic w, r, c, input logic [27:0] d);
    @(negedge clk);
    wr0 = w; rd0 = r; clr0 = c; din0 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input logic w, r, input logic [27:0] d);
    @(negedge clk);
    wr1 = w; rd1 = r; din1 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fill 33 (last rejected), drain 33 (last rejected), then clear errors
    for (int i = 1; i <= 33; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 28'(i), 6'(i > 32 ? 32 : i), i == 33, 1'b0, 28'd0));
    for (int j = 1; j <= 33; j++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 28'd0, 6'(j > 32 ? 0 : 32 - j), 1'b1, j == 33, 28'(j > 32 ? 32 : j)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 28'd0, 6'd0, 1'b0, 1'b0, 28'h20));

    {rst0, wr0, rd0, clr0, din0} = '0;
    {rst1, wr1, rd1, clr1, din1} = '0;
    {rst2, wr2, rd2, clr2, din2} = '0;
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle0_%0d", i), {usedw0, empty0, full0, afull0, aempty0, ovf0, udf0, dout0},
          {6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0});
      chk($sformatf("idle1_%0d", i), {usedw1, empty1, full1, afull1, aempty1, ovf1, udf1, dout1},
          {6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0});
    end

    for (int k = 0; k < tbl.size(); k++) begin
      cyc0(tbl[k].wr, tbl[k].rd, tbl[k].clr, tbl[k].din);
      chk($sformatf("vec%0d", k), {usedw0, empty0, full0, afull0, aempty0, ovf0, udf0, dout0},
          {tbl[k].usedw, tbl[k].empty, tbl[k].full, tbl[k].afull, tbl[k].aempty, tbl[k].ovf, tbl[k].udf, tbl[k].dout});
    end

    // steady state at usedw=5 with simultaneous wr+rd
    for (int i = 0; i < 5; i++) begin
      dv = 28'($urandom);
      cyc0(1'b1, 1'b0, 1'b0, dv);
      q0.push_back(dv);
    end
    for (int i = 0; i < 100; i++) begin
      dv = 28'($urandom);
      cyc0(1'b1, 1'b1, 1'b0, dv);
      ev = q0.pop_front();
      q0.push_back(dv);
      chk($sformatf("wr_rd5_%0d", i), {usedw0, dout0}, {6'd5, ev});
    end
    for (int i = 0; i < 5; i++) begin
      cyc0(1'b0, 1'b1, 1'b0, 28'd0);
      ev = q0.pop_front();
      chk("drain5", {usedw0, dout0}, {6'(4 - i), ev});
    end
    dv = 28'h1234567;
    cyc0(1'b1, 1'b1, 1'b0, dv);
    q0.push_back(dv);
    chk("wr_rd_empty", {usedw0, empty0, udf0}, {6'd1, 1'b0, 1'b1});
    cyc0(1'b0, 1'b0, 1'b1, 28'd0);
    chk("udf_clr", {udf0, ovf0}, {1'b0, 1'b0});
    for (int i = 0; i < 31; i++) begin
      dv = 28'($urandom);
      cyc0(1'b1, 1'b0, 1'b0, dv);
      q0.push_back(dv);
    end
    chk("full32", {usedw0, full0, afull0}, {6'd32, 1'b1, 1'b1});
    cyc0(1'b1, 1'b1, 1'b0, 28'hFFFFFFF);
    ev = q0.pop_front();
    chk("wr_rd_full", {usedw0, full0, ovf0, dout0}, {6'd31, 1'b0, 1'b1, ev});
    cyc0(1'b0, 1'b0, 1'b1, 28'd0);
    chk("ovf_clr", ovf0, 1'b0);
    dv = 28'h0C0FFEE;
    cyc0(1'b1, 1'b0, 1'b0, dv);
    q0.push_back(dv);
    cyc0(1'b1, 1'b0, 1'b1, 28'h5555555);
    chk("set_beats_clr", {usedw0, ovf0}, {6'd32, 1'b1});
    cyc0(1'b0, 1'b0, 1'b1, 28'd0);
    chk("ovf_clr2", ovf0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc0(1'b0, 1'b1, 1'b0, 28'd0);
      ev = q0.pop_front();
      chk("drain17", dout0, ev);
    end
    chk("at17", usedw0, 6'd17);
    rst0 = 1'b1;
    cyc0(1'b0, 1'b0, 1'b0, 28'd0);
    rst0 = 1'b0;
    q0.delete();
    chk("mid_rst", {usedw0, empty0, full0, afull0, aempty0, ovf0, udf0, dout0},
        {6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0});
    for (int i = 0; i < 3; i++) begin
      dv = 28'h100 + 28'(i);
      cyc0(1'b1, 1'b0, 1'b0, dv);
      q0.push_back(dv);
    end
    for (int i = 0; i < 3; i++) begin
      cyc0(1'b0, 1'b1, 1'b0, 28'd0);
      ev = q0.pop_front();
      chk("post_rst_order", {usedw0, dout0}, {6'(2 - i), ev});
    end

    // FWFT: written word shows up without a read
    cyc1(1'b1, 1'b0, 28'hABCDEF1);
    chk("fwft_first", {empty1, usedw1, dout1}, {1'b0, 6'd1, 28'hABCDEF1});
    cyc1(1'b1, 1'b0, 28'h0000BEE);
    chk("fwft_hold", {usedw1, dout1}, {6'd2, 28'hABCDEF1});
    cyc1(1'b0, 1'b1, 28'd0);
    chk("fwft_pop1", {empty1, usedw1, dout1}, {1'b0, 6'd1, 28'h0000BEE});
    cyc1(1'b0, 1'b1, 28'd0);
    chk("fwft_pop2", {empty1, usedw1, udf1}, {1'b1, 6'd0, 1'b0});

    // randomized 8x8 traffic against a queue model, both read modes
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0; w_pct = 50;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c % 100 == 0) w_pct = $urandom_range(20, 80);
      wr2 = $urandom_range(0, 99) < w_pct;
      rd2 = $urandom_range(0, 99) < 100 - w_pct;
      clr2 = $urandom_range(0, 19) == 0;
      rst2 = $urandom_range(0, 299) == 0;
      din2 = 8'($urandom);
      if (rst2) begin
        q2.delete();
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
        s_ovf = wr2 && q2.size() == 8;
        s_udf = rd2 && q2.size() == 0;
        if (rd2 && q2.size() > 0) m_dout = q2.pop_front();
        if (wr2 && !s_ovf) q2.push_back(din2);
        m_ovf = s_ovf ? 1'b1 : clr2 ? 1'b0 : m_ovf;
        m_udf = s_udf ? 1'b1 : clr2 ? 1'b0 : m_udf;
      end
      @(posedge clk);
      #1;
      n = q2.size();
      chk($sformatf("rnd_std_%0d", c), {usedw2, empty2, full2, afull2, aempty2, ovf2, udf2, dout2},
          {4'(n), n == 0, n == 8, n >= 6, n <= 2, m_ovf, m_udf, m_dout});
      chk($sformatf("rnd_fwft_%0d", c), {usedw3, empty3, full3, afull3, aempty3, ovf3, udf3},
          {4'(n), n == 0, n == 8, n >= 6, n <= 2, m_ovf, m_udf});
      if (n > 0) chk($sformatf("rnd_fwft_dout_%0d", c), dout3, q2[0]);
    end
    {wr2, rd2, clr2, rst2} = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
